// File: rtl/uart_tx_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine_pkg
// Description : Definitions shared by the UART transmit engine: the FSM state
//               encoding, the frame and counter sizes, the default baud
//               counter width and the parity helper functions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } tx_state_t;

  localparam int FRAME_BITS     = 11;
  localparam int BIT_CNT_W      = 4;
  localparam int DEFAULT_BAUD_W = 19;

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity7(input logic [6:0] d);
    return ^d;
  endfunction

  function automatic logic even_parity8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage : uart_tx_engine_pkg
`default_nettype wire

// File: rtl/uart_tx_engine_frame_decode.sv
`default_nettype none
// ============================================================================
// Module      : tx_frame_decode
// Description : Combinational decode of frame bits 9 and 10 from the latched
//               character configuration and data byte.
// Ports       : eight  - 1 = 8 data bits, 0 = 7 data bits
//               pen    - parity enable
//               ohel   - 1 = odd parity, 0 = even parity
//               data   - latched byte
//               bit_9  - frame bit 9 (d7 or 7-bit parity or idle 1)
//               bit_10 - frame bit 10 (8-bit parity or 1)
// Revision    : 1.0 - initial release
// ============================================================================
module tx_frame_decode
  import uart_tx_engine_pkg::*;
(
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic [7:0] data,
  output logic       bit_9,
  output logic       bit_10
);

  always_comb begin
    bit_9  = 1'b1;
    bit_10 = 1'b1;
    if (eight) begin
      bit_9 = data[7];
      if (pen) begin
        // Odd parity is simply the complement of even parity.
        bit_10 = ohel ? ~even_parity8(data) : even_parity8(data);
      end
    end else if (pen) begin
      bit_9 = ohel ? ~even_parity7(data[6:0]) : even_parity7(data[6:0]);
    end
  end

endmodule : tx_frame_decode
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine
// Description : UART transmit controller. Latches a byte and its frame
//               configuration, builds an 11-bit frame and shifts it out LSB
//               first on tx, one bit per max(baud_k,1) clocks.
// Ports       : clk      - system clock, rising edge
//               reset    - synchronous active-high reset
//               load     - write strobe, honoured only while tx_ready
//               data     - byte to transmit
//               EIGHT    - 1 = 8 data bits, 0 = 7 data bits
//               PEN      - parity enable
//               OHEL     - 1 = odd parity, 0 = even parity
//               baud_k   - clocks per bit (0 behaves as 1)
//               tx       - serial output, idles high
//               tx_ready - idle and able to accept load
//               tx_done  - one-cycle pulse at frame completion
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine
  import uart_tx_engine_pkg::*;
#(
  parameter int BAUD_W = DEFAULT_BAUD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [7:0]        data,
  input  logic              EIGHT,
  input  logic              PEN,
  input  logic              OHEL,
  input  logic [BAUD_W-1:0] baud_k,
  output logic              tx,
  output logic              tx_ready,
  output logic              tx_done
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  tx_state_t                state;
  logic [7:0]               data_q;
  logic                     eight_q;
  logic                     pen_q;
  logic                     ohel_q;
  logic [BAUD_W-1:0]        baud_max;
  logic [BAUD_W-1:0]        baud_cnt;
  logic [BIT_CNT_W-1:0]     bit_cnt;
  logic [FRAME_BITS-1:0]    shift_reg;
  logic                     bit_9;
  logic                     bit_10;
  logic [FRAME_BITS-1:0]    frame;

  tx_frame_decode u_frame_decode (
    .eight  (eight_q),
    .pen    (pen_q),
    .ohel   (ohel_q),
    .data   (data_q),
    .bit_9  (bit_9),
    .bit_10 (bit_10)
  );

  // LSB leaves first: start, d0..d6, bit_9, bit_10, stop.
  assign frame = {1'b1, bit_10, bit_9, data_q[6:0], 1'b0};

  // The shift register idles all ones, so tx is high whenever no frame is
  // in flight and always comes straight from a flop.
  assign tx = shift_reg[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      eight_q   <= 1'b0;
      pen_q     <= 1'b0;
      ohel_q    <= 1'b0;
      baud_max  <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '1;
      tx_ready  <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            data_q   <= data;
            eight_q  <= EIGHT;
            pen_q    <= PEN;
            ohel_q   <= OHEL;
            // Store the terminal count so baud_k=0 and baud_k=1 coincide.
            baud_max <= (baud_k == '0) ? '0 : baud_k - BAUD_W'(1);
            tx_ready <= 1'b0;
            state    <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          shift_reg <= frame;
          bit_cnt   <= '0;
          baud_cnt  <= '0;
          state     <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (baud_cnt == baud_max) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              tx_ready <= 1'b1;
              tx_done  <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          shift_reg <= '1;
          tx_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : uart_tx_engine
`default_nettype wire
